// File: rtl/mem_arbiter_multi_if.sv
// rtl/mem_arbiter_multi_if.sv - cache-side and memory-side bus bundle for mem_arbiter_multi
interface mem_arbiter_multi_if #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_en;
  logic               mem_wr;
  logic [DW-1:0]      mem_rdata;
  logic               mem_valid;

  // arbiter side
  modport slave (
    input  req, we, addr, wdata, mem_rdata, mem_valid,
    output grant, done, err, rdata, mem_addr, mem_wdata, mem_en, mem_wr
  );

  // requesters plus memory model side
  modport master (
    output req, we, addr, wdata, mem_rdata, mem_valid,
    input  grant, done, err, rdata, mem_addr, mem_wdata, mem_en, mem_wr
  );
endinterface

// File: rtl/mem_arbiter_multi.sv
// rtl/mem_arbiter_multi.sv - N-port memory arbiter with fixed-priority/round-robin selection
module mem_arbiter_multi #(
  parameter int NREQ    = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MODE    = 0,
  parameter int WR_LAT  = 4,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  mem_arbiter_multi_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  win;
  logic [IW-1:0]  win_sel;
  logic [IW-1:0]  ptr;
  logic           sel_valid;
  logic           wr_q;
  logic           err_q;
  // counts cycles since mem_en: zero in ISSUE, one in the first WAIT cycle
  logic [CW-1:0]  cnt;
  logic [DW-1:0]  rdata_q;
  logic [AW-1:0]  maddr_q;
  logic [DW-1:0]  mwdata_q;

  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

  // winner selection: lowest index, or first requester after the last completed port
  always_comb begin
    win_sel   = '0;
    sel_valid = 1'b0;
    if (MODE == 0) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (bus.req[i]) begin
          win_sel   = IW'(i);
          sel_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        if (bus.req[(int'(ptr) + k) % NREQ]) begin
          win_sel   = IW'((int'(ptr) + k) % NREQ);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // next state and per-state outputs
  always_comb begin
    state_nxt  = state;
    bus.grant  = '0;
    bus.done   = '0;
    bus.err    = 1'b0;
    bus.mem_en = 1'b0;
    bus.mem_wr = 1'b0;
    if (state != IDLE) bus.grant[win] = 1'b1;
    case (state)
      IDLE: begin
        if (sel_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_wr = wr_q;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (wr_q) begin
          if (cnt == CW'(WR_LAT - 1)) state_nxt = DONE;
        end else if (bus.mem_valid || cnt == CW'(TIMEOUT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done[win] = 1'b1;
        bus.err       = err_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // request latch, wait counter, read capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      win      <= '0;
      ptr      <= IW'(NREQ - 1);
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          if (sel_valid) begin
            win      <= win_sel;
            wr_q     <= bus.we[win_sel];
            maddr_q  <= bus.addr[int'(win_sel) * AW +: AW];
            mwdata_q <= bus.wdata[int'(win_sel) * DW +: DW];
          end
        end
        ISSUE: cnt <= cnt + CW'(1);
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (!wr_q) begin
            if (bus.mem_valid)             rdata_q <= bus.mem_rdata;
            else if (cnt == CW'(TIMEOUT))  err_q   <= 1'b1;
          end
        end
        DONE: ptr <= win;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_multi.sv
// tb/tb_mem_arbiter_multi.sv - self-checking bench for mem_arbiter_multi in both selection modes
module tb_mem_arbiter_multi;
  localparam int NREQ    = 2;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int WR_LAT  = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  mem_arbiter_multi_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus0 ();
  mem_arbiter_multi_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus1 ();

  assign bus0.req = req;  assign bus0.we = we;  assign bus0.addr = addr;  assign bus0.wdata = wdata;
  assign bus0.mem_rdata = mem_rdata;  assign bus0.mem_valid = mem_valid;
  assign bus1.req = req;  assign bus1.we = we;  assign bus1.addr = addr;  assign bus1.wdata = wdata;
  assign bus1.mem_rdata = mem_rdata;  assign bus1.mem_valid = mem_valid;

  mem_arbiter_multi #(.NREQ(NREQ), .AW(AW), .DW(DW), .MODE(0), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_arbiter_multi #(.NREQ(NREQ), .AW(AW), .DW(DW), .MODE(1), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: event not seen within cycle budget", name, cyc);
  endtask

  // Transaction-level model, one per mode: a transaction is a winner plus
  // the cycle numbers of its mem_en and done.
  bit          m_busy [2] = '{0, 0};
  int          m_w    [2] = '{0, 0};
  bit          m_wr   [2] = '{0, 0};
  int          m_ten  [2] = '{0, 0};
  int          m_tdone[2] = '{-1, -1};
  bit          m_err  [2] = '{0, 0};
  int          m_ptr  [2] = '{NREQ - 1, NREQ - 1};
  logic [15:0] m_rdata[2] = '{16'h0, 16'h0};
  logic [15:0] m_maddr[2] = '{16'h0, 16'h0};
  logic [15:0] m_mwdat[2] = '{16'h0, 16'h0};

  task automatic model_step(input int m, input logic [1:0] g, input logic [1:0] d, input logic e,
                            input logic en, input logic wr, input logic [15:0] rd,
                            input logic [15:0] ma, input logic [15:0] mw);
    logic [1:0] eg, ed;
    logic       een;
    int         w;
    eg  = m_busy[m] ? 2'(1 << m_w[m]) : 2'b00;
    een = m_busy[m] && (cyc == m_ten[m]);
    ed  = (m_busy[m] && cyc == m_tdone[m]) ? eg : 2'b00;
    check($sformatf("m%0d_grant", m), g, eg);
    check($sformatf("m%0d_done", m), d, ed);
    check($sformatf("m%0d_err", m), e, (ed != 0) && m_err[m]);
    check($sformatf("m%0d_mem_en", m), en, een);
    check($sformatf("m%0d_mem_wr", m), wr, een && m_wr[m]);
    check($sformatf("m%0d_rdata", m), rd, m_rdata[m]);
    check($sformatf("m%0d_mem_addr", m), ma, m_maddr[m]);
    check($sformatf("m%0d_mem_wdata", m), mw, m_mwdat[m]);
    if (!rst) begin
      m_busy[m] = 0; m_ptr[m] = NREQ - 1; m_err[m] = 0;
      m_rdata[m] = '0; m_maddr[m] = '0; m_mwdat[m] = '0;
    end else if (m_busy[m]) begin
      if (cyc == m_tdone[m]) begin
        m_busy[m] = 0;
        m_ptr[m]  = m_w[m];
      end else if (!m_wr[m] && m_tdone[m] < 0) begin
        if (cyc > m_ten[m] && mem_valid) begin
          m_tdone[m] = cyc + 1;
          m_rdata[m] = mem_rdata;
        end else if (cyc == m_ten[m] + TIMEOUT) begin
          m_tdone[m] = cyc + 1;
          m_err[m]   = 1;
        end
      end
    end else if (req != 0) begin
      w = -1;
      if (m == 0) begin
        for (int i = NREQ - 1; i >= 0; i--) if (req[i]) w = i;
      end else begin
        for (int k = NREQ; k >= 1; k--) if (req[(m_ptr[m] + k) % NREQ]) w = (m_ptr[m] + k) % NREQ;
      end
      m_busy[m]  = 1;
      m_w[m]     = w;
      m_wr[m]    = we[w];
      m_maddr[m] = addr[w * AW +: AW];
      m_mwdat[m] = wdata[w * DW +: DW];
      m_ten[m]   = cyc + 1;
      m_tdone[m] = we[w] ? cyc + 1 + WR_LAT : -1;
      m_err[m]   = 0;
    end
  endtask

  // compare both DUTs against the model every cycle
  always @(negedge clk) begin
    model_step(0, bus0.grant, bus0.done, bus0.err, bus0.mem_en, bus0.mem_wr, bus0.rdata, bus0.mem_addr, bus0.mem_wdata);
    model_step(1, bus1.grant, bus1.done, bus1.err, bus1.mem_en, bus1.mem_wr, bus1.rdata, bus1.mem_addr, bus1.mem_wdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          r_ten, r_tdone;
  logic        r_err, r_wr;
  logic [1:0]  r_done;
  logic [15:0] r_maddr, r_mwdata;

  task automatic run_txn(input int port, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input int vdel);
    req[port] = 1'b1; we[port] = wr; addr[port*16 +: 16] = a; wdata[port*16 +: 16] = d;
    r_ten = -1; r_tdone = -1; r_err = 1'b0; r_done = '0;
    for (int i = 0; i < 60 && r_ten < 0; i++) begin
      step();
      if (bus0.mem_en) begin
        r_ten = cyc; r_wr = bus0.mem_wr; r_maddr = bus0.mem_addr; r_mwdata = bus0.mem_wdata;
      end
    end
    if (r_ten < 0) begin
      bound_fail("txn_mem_en");
      req[port] = 1'b0;
      return;
    end
    for (int i = 0; i < 60 && r_tdone < 0; i++) begin
      step();
      mem_valid = (vdel >= 0) && (cyc == r_ten + vdel);
      if (bus0.done != 0) begin
        r_tdone = cyc; r_err = bus0.err; r_done = bus0.done; req[port] = 1'b0;
      end
    end
    mem_valid = 1'b0;
    if (r_tdone < 0) begin
      bound_fail("txn_done");
      req[port] = 1'b0;
    end
  endtask

  logic [1:0] g0 [4];
  logic [1:0] g1 [4];
  int         n, tsave;
  bit         seen;

  initial begin
    // 1: reset with both ports requesting writes
    req = 2'b11; we = 2'b11; addr = {16'h0002, 16'h0001}; wdata = {16'h2222, 16'h1111};
    repeat (3) begin
      step();
      check("rst_grant0", bus0.grant, 2'b00);
      check("rst_grant1", bus1.grant, 2'b00);
      check("rst_mem_en", bus0.mem_en, 1'b0);
      check("rst_done", bus0.done, 2'b00);
    end
    rst = 1'b1;
    step();
    check("release_grant0", bus0.grant, 2'b01);
    check("release_grant1", bus1.grant, 2'b01);
    req = 2'b00;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = (bus0.done != 0); end
    if (!seen) bound_fail("t1_done");
    step();

    // 2: port 1 read, mem_valid three cycles after mem_en
    mem_rdata = 16'hBEEF;
    run_txn(1, 1'b0, 16'h0040, 16'h0000, 3);
    check("t2_latency", r_tdone - r_ten, 4);
    check("t2_done", r_done, 2'b10);
    check("t2_mem_addr", r_maddr, 16'h0040);
    check("t2_rdata0", bus0.rdata, 16'hBEEF);
    check("t2_rdata1", bus1.rdata, 16'hBEEF);
    step();
    check("t2_grant_idle", bus0.grant, 2'b00);

    // 3: port 1 write
    run_txn(1, 1'b1, 16'h0010, 16'h1234, -1);
    check("t3_mem_wr", r_wr, 1'b1);
    check("t3_mem_addr", r_maddr, 16'h0010);
    check("t3_mem_wdata", r_mwdata, 16'h1234);
    check("t3_latency", r_tdone - r_ten, 4);
    check("t3_done", r_done, 2'b10);
    step();

    // 4: both ports writing continuously for four transactions
    req = 2'b11; we = 2'b11; addr = {16'h0020, 16'h0030}; wdata = {16'hAAAA, 16'h5555};
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      step();
      if (bus0.mem_en) begin g0[n] = bus0.grant; g1[n] = bus1.grant; n++; end
    end
    check("t4_count", n, 4);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = (bus0.done != 0); end
    if (!seen) bound_fail("t4_done");
    req = 2'b00;
    for (int i = 0; i < n; i++) begin
      check($sformatf("t4_fixed_%0d", i), g0[i], 2'b01);
      check($sformatf("t4_rr_%0d", i), g1[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    step();

    // 5: read that never gets mem_valid
    mem_rdata = 16'h1111;
    run_txn(0, 1'b0, 16'h0080, 16'h0000, -1);
    check("t5_latency", r_tdone - r_ten, TIMEOUT + 1);
    check("t5_err", r_err, 1'b1);
    check("t5_done", r_done, 2'b01);
    check("t5_rdata0", bus0.rdata, 16'hBEEF);
    check("t5_rdata1", bus1.rdata, 16'hBEEF);
    step();

    // 6a: req drop and address change during WAIT are ignored
    req[0] = 1'b1; we[0] = 1'b1; addr[15:0] = 16'h0100; wdata[15:0] = 16'h5555;
    tsave = -1;
    for (int i = 0; i < 30 && tsave < 0; i++) begin step(); if (bus0.mem_en) tsave = cyc; end
    if (tsave < 0) bound_fail("t6_mem_en");
    step();
    req[0] = 1'b0; addr[15:0] = 16'h0F0F;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (bus0.done != 0) begin
        seen = 1;
        check("t6_done", bus0.done, 2'b01);
        check("t6_mem_addr", bus0.mem_addr, 16'h0100);
        check("t6_latency", cyc - tsave, WR_LAT);
      end
    end
    if (!seen) bound_fail("t6_done");
    step();

    // 6b: reset in the middle of WAIT aborts without done
    req[0] = 1'b1; addr[15:0] = 16'h0200;
    tsave = -1;
    for (int i = 0; i < 30 && tsave < 0; i++) begin step(); if (bus0.mem_en) tsave = cyc; end
    if (tsave < 0) bound_fail("t6b_mem_en");
    step();
    step();
    rst = 1'b0; req = 2'b00;
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t6b_no_done", bus0.done | bus1.done, 2'b00);
      check("t6b_idle", bus0.grant | bus1.grant, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
